resp_tx_sched: RTL

RESP_TX_SCHED -- requirements
Module: resp_tx_sched

---
 rtl/resp_tx_sched.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/resp_tx_sched.sv
// Response transmit scheduler: ALU (2-byte) and REG (1-byte) holding slots serialised to a UART TX
// with round-robin slot selection and a SEND timeout. Define RESP_SCHED_DROP_CNT_EN to add DROP_CNT.
module resp_tx_sched #(
    parameter int width    = 8,
    parameter int BUSY_TMO = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [15:0]      ALU_OUT,
    input  logic             OUT_VALID,
    input  logic [width-1:0] RdData,
    input  logic             RdData_Valid,
    input  logic             Busy,
    output logic [width-1:0] TX_DATA,
    output logic             TX_D_VLD,
    output logic             RESP_PEND,
    output logic             OVF,
    output logic             TMO_ERR
`ifdef RESP_SCHED_DROP_CNT_EN
    ,
    output logic [7:0]       DROP_CNT
`endif
);

    // state     | meaning
    // S_IDLE    | no frame in flight; waits for a full slot and Busy low
    // S_SEND    | TX_D_VLD raised with TX_DATA stable; waits for Busy high or timeout
    // S_WAIT_LO | byte accepted; waits for Busy low before next byte or frame end
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_WAIT_LO = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(BUSY_TMO - 1);

    state_t           state_q, state_d;
    logic             alu_full_q, alu_full_d;
    logic             reg_full_q, reg_full_d;
    logic [15:0]      alu_q, alu_d;
    logic [width-1:0] reg_q, reg_d;
    logic             sel_q, sel_d;     // slot in flight: 1 = REG, 0 = ALU
    logic             last_q, last_d;   // last served slot: 1 = REG, 0 = ALU
    logic             more_q, more_d;   // ALU high byte still to send
    logic [7:0]       cnt_q, cnt_d;
    logic [width-1:0] tx_data_q, tx_data_d;
    logic             ovf_q, ovf_d;
    logic             tmo_q, tmo_d;

    logic             frame_done;
    logic             pick_reg;
    logic             alu_free, reg_free;
    logic             alu_take, reg_take;
    logic [width-1:0] alu_lo, alu_hi;

    assign alu_lo   = width'(alu_q[7:0]);
    assign alu_hi   = width'(alu_q[15:8]);
    assign pick_reg = reg_full_q && (!alu_full_q || !last_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            alu_full_q <= 1'b0;
            reg_full_q <= 1'b0;
            alu_q      <= '0;
            reg_q      <= '0;
            sel_q      <= 1'b0;
            last_q     <= 1'b1;
            more_q     <= 1'b0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_full_q <= alu_full_d;
            reg_full_q <= reg_full_d;
            alu_q      <= alu_d;
            reg_q      <= reg_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            more_q     <= more_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        more_d     = more_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        frame_done = 1'b0;
        tmo_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!Busy && (alu_full_q || reg_full_q)) begin
                    sel_d     = pick_reg;
                    last_d    = pick_reg;
                    more_d    = !pick_reg;
                    tx_data_d = pick_reg ? reg_q : alu_lo;
                    cnt_d     = '0;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (Busy) begin
                    state_d = S_WAIT_LO;
                end else if (cnt_q == TMO_LAST) begin
                    frame_done = 1'b1;
                    tmo_d      = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT_LO: begin
                if (!Busy) begin
                    if (more_q) begin
                        tx_data_d = alu_hi;
                        more_d    = 1'b0;
                        cnt_d     = '0;
                        state_d   = S_SEND;
                    end else begin
                        frame_done = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // a slot freed this cycle may be refilled by a strobe in the same cycle
        alu_free   = frame_done && !sel_q;
        reg_free   = frame_done && sel_q;
        alu_take   = OUT_VALID && (!alu_full_q || alu_free);
        reg_take   = RdData_Valid && (!reg_full_q || reg_free);
        alu_full_d = (alu_full_q && !alu_free) || alu_take;
        reg_full_d = (reg_full_q && !reg_free) || reg_take;
        alu_d      = alu_take ? ALU_OUT : alu_q;
        reg_d      = reg_take ? RdData : reg_q;
        ovf_d      = (OUT_VALID && !alu_take) || (RdData_Valid && !reg_take);
    end

    always_comb begin
        TX_D_VLD  = (state_q == S_SEND);
        TX_DATA   = tx_data_q;
        RESP_PEND = alu_full_q || reg_full_q || (state_q != S_IDLE);
        OVF       = ovf_q;
        TMO_ERR   = tmo_q;
    end

`ifdef RESP_SCHED_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (ovf_d && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign DROP_CNT = drop_cnt_q;
`endif

endmodule
